// File: rtl/demux_1x4_hs_pkg.sv
// Shared definitions for the registered 1-to-4 handshake demultiplexer.
// Holds the default data width, channel count and select encodings.
package demux_1x4_hs_pkg;

    localparam int WIDTH_DEF = 12;
    localparam int NOUT      = 4;

    typedef enum logic [1:0] {
        SEL_CH0 = 2'b00,
        SEL_CH1 = 2'b01,
        SEL_CH2 = 2'b10,
        SEL_CH3 = 2'b11
    } sel_e;

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: a single-word valid/data holding register.
// Ports: clk, reset, load, load_data, drain_ready -> valid, data, can_accept.
module demux_out_slot #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A full slot can still accept when its word leaves this cycle.
    assign can_accept = !valid_q || drain_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            // Load wins over drain so a refill causes no bubble.
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && drain_ready) begin
            // Data is kept on drain; only valid drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux_1x4_hs.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready handshake.
// Ports: clk, reset, in_data/in_sel/in_valid -> in_ready; out_data/out_valid <- out_ready.
module demux_1x4_hs
    import demux_1x4_hs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NOUT*WIDTH-1:0] out_data,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready
);

    logic [NOUT-1:0] load;
    logic [NOUT-1:0] can_accept;

    // Readiness follows the current select; held low during reset.
    assign in_ready = !reset && can_accept[in_sel];

    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            case (in_sel)
                SEL_CH0: load = 4'b0001;
                SEL_CH1: load = 4'b0010;
                SEL_CH2: load = 4'b0100;
                SEL_CH3: load = 4'b1000;
                default: load = '0;
            endcase
        end
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        demux_out_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .load       (load[k]),
            .load_data  (in_data),
            .drain_ready(out_ready[k]),
            .valid      (out_valid[k]),
            .data       (out_data[k*WIDTH +: WIDTH]),
            .can_accept (can_accept[k])
        );
    end

endmodule

// File: tb/tb_demux_1x4_hs.sv
// Self-checking bench for demux_1x4_hs.
// Directed scenarios plus random traffic against a per-channel array model.
module tb_demux_1x4_hs;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each channel is a depth-1 buffer.
    bit        m_full [4];
    bit [11:0] m_word [4];

    int drains;

    demux_1x4_hs dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [47:0] got,
                         input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle, check DUT against model, then advance both.
    task automatic step(input bit rst, input bit iv,
                        input logic [1:0] sel, input logic [11:0] d,
                        input logic [3:0] ordy);
        bit          exp_rdy;
        logic [3:0]  exp_v;
        logic [47:0] exp_d;
        reset     = rst;
        in_valid  = iv;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = !rst && (!m_full[sel] || ordy[sel]);
        for (int k = 0; k < 4; k++) begin
            exp_v[k]          = m_full[k];
            exp_d[k*12 +: 12] = m_word[k];
        end
        check("in_ready", {47'd0, in_ready}, {47'd0, exp_rdy});
        check("out_valid", {44'd0, out_valid}, {44'd0, exp_v});
        check("out_data", out_data, exp_d);
        for (int k = 0; k < 4; k++)
            if (out_valid[k] && ordy[k] && k == 0) drains++;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                m_full[k] = 0;
                m_word[k] = '0;
            end else if (iv && exp_rdy && sel == k[1:0]) begin
                m_full[k] = 1;
                m_word[k] = d;
            end else if (m_full[k] && ordy[k]) begin
                m_full[k] = 0;
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sel = 2'b00;
        in_data = '0; out_ready = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0;
            m_word[k] = '0;
        end

        // Reset held with a live input.
        step(1, 1, 2'b01, 12'hABC, 4'b1111);
        step(1, 1, 2'b01, 12'hABC, 4'b1111);
        check("rst_valid", {44'd0, out_valid}, 48'd0);
        check("rst_data", out_data, 48'd0);

        // Basic routing.
        step(0, 1, 2'd0, 12'h111, 4'b1111);
        step(0, 1, 2'd1, 12'h222, 4'b1111);
        step(0, 1, 2'd2, 12'h333, 4'b1111);
        step(0, 1, 2'd3, 12'h444, 4'b1111);
        check("route_ch3", {36'd0, out_data[47:36]}, 48'h444);
        step(0, 0, 2'd0, 12'h000, 4'b1111);

        // Backpressure on ch2, then drain+refill in one edge.
        step(0, 1, 2'd2, 12'h5A5, 4'b1011);
        step(0, 1, 2'd2, 12'h0F0, 4'b1011);
        step(0, 1, 2'd2, 12'h0F0, 4'b1111);
        check("refill_v2", {47'd0, out_valid[2]}, 48'd1);
        check("refill_d2", {36'd0, out_data[35:24]}, 48'h0F0);
        step(0, 0, 2'd0, 12'h000, 4'b1111);

        // Independence: ch1 full and stalled, ch3 still loads.
        step(0, 1, 2'd1, 12'h666, 4'b1101);
        step(0, 1, 2'd3, 12'h777, 4'b0101);
        step(0, 0, 2'd1, 12'h000, 4'b0101);
        check("indep_ch1", {36'd0, out_data[23:12]}, 48'h666);
        step(0, 0, 2'd0, 12'h000, 4'b1111);

        // Throughput: 16 back-to-back words to ch0.
        drains = 0;
        for (int i = 0; i < 16; i++)
            step(0, 1, 2'd0, 12'(i), 4'b0001);
        step(0, 0, 2'd0, 12'h000, 4'b0001);
        check("thru_drains", 48'(drains), 48'd16);
        step(0, 0, 2'd0, 12'h000, 4'b1111);

        // Reset mid-operation with ch0 and ch3 stalled full.
        step(0, 1, 2'd0, 12'h9C0, 4'b0000);
        step(0, 1, 2'd3, 12'h9C3, 4'b0000);
        step(1, 0, 2'd0, 12'h000, 4'b0000);
        check("midrst_v", {44'd0, out_valid}, 48'd0);
        step(0, 1, 2'd0, 12'h123, 4'b0000);
        step(0, 0, 2'd0, 12'h000, 4'b1111);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, 1'($urandom),
                 2'($urandom), 12'($urandom), 4'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
